// File: rtl/injetor_ncl_ula.sv
// Binary-to-NCL dual-rail injector: latches an operand set and presents it as DATA/NULL wavefronts.
// Optional watchdog on the DATA phase is built when INJETOR_NCL_TIMEOUT_EN is defined.
module injetor_ncl_ula #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic [WIDTH-1:0] a_t,
    output logic [WIDTH-1:0] a_f,
    output logic [WIDTH-1:0] b_t,
    output logic [WIDTH-1:0] b_f,
    output logic [1:0]       op_t,
    output logic [1:0]       op_f,
    input  logic             ack_in,
    output logic [15:0]      tok_cnt,
    output logic             erro
);

    typedef enum logic {
        NULO = 1'b0,
        DADO = 1'b1
    } state_t;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("injetor_ncl_ula: TIMEOUT must be in 1..65535");
    end

    state_t           r_state;
    state_t           w_next;
    logic             r_ack_m;
    logic             r_ack_s;
    logic             w_accept;
    logic             w_release;
    logic [WIDTH-1:0] r_a_t, r_a_f, r_b_t, r_b_f;
    logic [1:0]       r_op_t, r_op_f;
    logic [15:0]      r_tok_cnt;

    // ack_in comes from the self-timed domain; only r_ack_s may steer control.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_m <= 1'b0;
            r_ack_s <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make the two flops form a real shift chain.
            r_ack_m <= ack_in;
            r_ack_s <= r_ack_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= NULO;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        w_next    = r_state;
        in_ready  = 1'b0;
        w_accept  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            NULO: begin
                in_ready = r_ack_s;
                if (in_valid && r_ack_s) begin
                    w_accept = 1'b1;
                    w_next   = DADO;
                end
            end
            DADO: begin
                if (!r_ack_s) begin
                    w_release = 1'b1;
                    w_next    = NULO;
                end
            end
            default: w_next = NULO;
        endcase
    end

    // Rails only ever move NULL->DATA on accept and DATA->NULL on release, so no DATA->DATA step exists.
    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_a_t  <= '0;
            r_a_f  <= '0;
            r_b_t  <= '0;
            r_b_f  <= '0;
            r_op_t <= '0;
            r_op_f <= '0;
        end else if (w_accept) begin
            r_a_t  <= in_a;
            r_a_f  <= ~in_a;
            r_b_t  <= in_b;
            r_b_f  <= ~in_b;
            r_op_t <= in_op;
            r_op_f <= ~in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)            r_tok_cnt <= 16'h0000;
        else if (w_release) r_tok_cnt <= r_tok_cnt + 16'h0001;
    end

    assign a_t     = r_a_t;
    assign a_f     = r_a_f;
    assign b_t     = r_b_t;
    assign b_f     = r_b_f;
    assign op_t    = r_op_t;
    assign op_f    = r_op_f;
    assign tok_cnt = r_tok_cnt;

`ifdef INJETOR_NCL_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

    logic [15:0] r_tmo_cnt;
    logic        r_erro;

    // erro rises on the same edge the count reaches TMO_LIMIT; the FSM keeps waiting regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= 16'h0000;
            r_erro    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tmo_cnt <= 16'h0000;
            end else if (r_state == DADO) begin
                if (r_tmo_cnt != 16'hFFFF) r_tmo_cnt <= r_tmo_cnt + 16'h0001;
                if (r_tmo_cnt + 16'h0001 == TMO_LIMIT) r_erro <= 1'b1;
            end
        end
    end

    assign erro = r_erro;
`else
    assign erro = 1'b0;
`endif

endmodule

// File: tb/tb_injetor_ncl_ula.sv
// Scoreboard bench for injetor_ncl_ula; exercises the watchdog when INJETOR_NCL_TIMEOUT_EN is defined.
module tb_injetor_ncl_ula;

    localparam int WIDTH   = 4;
    localparam int TIMEOUT = 8;

    typedef struct packed {
        logic [WIDTH-1:0] a_t;
        logic [WIDTH-1:0] a_f;
        logic [WIDTH-1:0] b_t;
        logic [WIDTH-1:0] b_f;
        logic [1:0]       op_t;
        logic [1:0]       op_f;
    } rails_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [1:0]       in_op = '0;
    logic [WIDTH-1:0] a_t, a_f, b_t, b_f;
    logic [1:0]       op_t, op_f;
    logic             ack_in = 1'b0;
    logic [15:0]      tok_cnt;
    logic             erro;

    rails_t      obs;
    rails_t      cur_rails;
    rails_t      exp_q[$];
    logic [15:0] exp_tok = 16'h0000;
    logic        exp_erro = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    injetor_ncl_ula #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .a_t(a_t), .a_f(a_f), .b_t(b_t), .b_f(b_f), .op_t(op_t), .op_f(op_f),
        .ack_in(ack_in), .tok_cnt(tok_cnt), .erro(erro)
    );

    always #5 clk = ~clk;

    assign obs = {a_t, a_f, b_t, b_f, op_t, op_f};

    function automatic rails_t encode(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                      input logic [1:0] op);
        rails_t r;
        for (int i = 0; i < WIDTH; i++) begin
            r.a_t[i] = (a[i] == 1'b1);
            r.a_f[i] = (a[i] == 1'b0);
            r.b_t[i] = (b[i] == 1'b1);
            r.b_f[i] = (b[i] == 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            r.op_t[i] = (op[i] == 1'b1);
            r.op_f[i] = (op[i] == 1'b0);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (in_ready !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ready: in_ready=%b, required 1 within %0d cycles", in_ready, budget);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [1:0] op);
        rails_t exp;
        wait_ready(8);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        exp_q.push_back(encode(a, b, op));
        tick();
        in_valid = 1'b0;
        exp = exp_q.pop_front();
        cur_rails = exp;
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL send_rails: got %h, required %h (a=%h b=%h op=%h)", obs, exp, a, b, op);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL send_ready_low: in_ready=%b, required 0 in DADO", in_ready);
        end
    endtask

    // Drop ack, expect DATA to hold 2 cycles and NULL on the 3rd, then re-arm ack.
    task automatic complete_token();
        ack_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (obs !== cur_rails) begin
                n_fail++;
                $display("FAIL complete_hold_%0d: got %h, required %h", i, obs, cur_rails);
            end
        end
        tick();
        exp_tok = exp_tok + 16'h0001;
        n_checks++;
        if (obs !== '0) begin
            n_fail++;
            $display("FAIL complete_null: got %h, required 0", obs);
        end
        n_checks++;
        if (tok_cnt !== exp_tok) begin
            n_fail++;
            $display("FAIL complete_tok: got %h, required %h", tok_cnt, exp_tok);
        end
        n_checks++;
        if (erro !== exp_erro) begin
            n_fail++;
            $display("FAIL complete_erro: got %b, required %b", erro, exp_erro);
        end
        ack_in = 1'b1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        ack_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        exp_tok  = 16'h0000;
        exp_erro = 1'b0;
        n_checks++;
        if (obs !== '0 || tok_cnt !== 16'h0000 || erro !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rails=%h tok=%h erro=%b, required 0/0000/0", obs, tok_cnt, erro);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_c0: in_ready=%b, required 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_c1: in_ready=%b, required 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_c2: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_encoding();
        send(4'b1010, 4'b0011, 2'b01);
        n_checks++;
        if (a_t !== 4'b1010 || a_f !== 4'b0101 || b_t !== 4'b0011 || b_f !== 4'b1100 ||
            op_t !== 2'b01 || op_f !== 2'b10) begin
            n_fail++;
            $display("FAIL encoding_fixed: got %h, required a 1010/0101 b 0011/1100 op 01/10", obs);
        end
        complete_token();
        for (int k = 0; k < 4; k++) begin
            send(WIDTH'($urandom_range(0, 15)), WIDTH'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
            complete_token();
        end
    endtask

    task automatic test_ignore_not_ready();
        wait_ready(8);
        ack_in = 1'b0;
        tick();
        tick();
        in_valid = 1'b1;
        in_a     = 4'hF;
        in_b     = 4'h5;
        in_op    = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (in_ready !== 1'b0 || obs !== '0) begin
                n_fail++;
                $display("FAIL ignore_%0d: in_ready=%b rails=%h, required 0/0", i, in_ready, obs);
            end
        end
        in_valid = 1'b0;
        ack_in   = 1'b1;
        n_checks++;
        if (tok_cnt !== exp_tok) begin
            n_fail++;
            $display("FAIL ignore_tok: got %h, required %h", tok_cnt, exp_tok);
        end
    endtask

    task automatic test_hold_in_dado();
        send(4'b0110, 4'b1001, 2'b10);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_a  = WIDTH'(i);
            in_b  = ~WIDTH'(i);
            in_op = 2'(i);
            tick();
            n_checks++;
            if (obs !== cur_rails || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_%0d: rails=%h ready=%b, required %h/0", i, obs, in_ready, cur_rails);
            end
        end
        in_valid = 1'b0;
        complete_token();
    endtask

    task automatic test_reset_in_dado();
        send(4'b1111, 4'b0000, 2'b11);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_tok  = 16'h0000;
        exp_erro = 1'b0;
        n_checks++;
        if (obs !== '0 || tok_cnt !== exp_tok) begin
            n_fail++;
            $display("FAIL reset_dado: rails=%h tok=%h, required 0/%h", obs, tok_cnt, exp_tok);
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dado_ready: in_ready=%b, required 0", in_ready);
        end
    endtask

    task automatic test_tok_wrap();
        wait_ready(8);
        force dut.r_tok_cnt = 16'hFFFE;
        #1;
        release dut.r_tok_cnt;
        exp_tok = 16'hFFFE;
        send(4'b0001, 4'b0010, 2'b00);
        complete_token();
        send(4'b1000, 4'b0100, 2'b11);
        complete_token();
        n_checks++;
        if (tok_cnt !== 16'h0000) begin
            n_fail++;
            $display("FAIL tok_wrap: got %h, required 0000", tok_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            send(WIDTH'(k * 3), WIDTH'(15 - k), 2'(k));
            complete_token();
        end
    endtask

    task automatic test_timeout();
`ifdef INJETOR_NCL_TIMEOUT_EN
        send(4'b0101, 4'b1010, 2'b01);
        for (int k = 1; k <= TIMEOUT; k++) begin
            tick();
            if (k == TIMEOUT - 1) begin
                n_checks++;
                if (erro !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_early: erro=%b after %0d cycles, required 0", erro, k);
                end
            end
        end
        exp_erro = 1'b1;
        n_checks++;
        if (erro !== 1'b1 || obs !== cur_rails) begin
            n_fail++;
            $display("FAIL timeout_set: erro=%b rails=%h, required 1/%h", erro, obs, cur_rails);
        end
        complete_token();
        send(4'b0011, 4'b0011, 2'b00);
        complete_token();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_erro = 1'b0;
        exp_tok  = 16'h0000;
        n_checks++;
        if (erro !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: erro=%b, required 0 after rst", erro);
        end
`else
        send(4'b0101, 4'b1010, 2'b01);
        for (int k = 0; k < 3 * TIMEOUT; k++) tick();
        n_checks++;
        if (erro !== 1'b0) begin
            n_fail++;
            $display("FAIL erro_tied: erro=%b, required 0 without watchdog", erro);
        end
        complete_token();
`endif
    endtask

    initial begin
        test_reset();
        test_encoding();
        test_ignore_not_ready();
        test_hold_in_dado();
        test_back_to_back();
        test_reset_in_dado();
        ack_in = 1'b1;
        test_tok_wrap();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/injetor_ncl_ula.md
INJETOR_NCL_ULA -- requirements
Module: injetor_ncl_ula

Interface
REQ-001 Parameter WIDTH, default 4, bit width of each ALU operand A and B.
REQ-002 Parameter TIMEOUT, default 255, maximum cycles a DATA wavefront may wait for ack_in to fall (range 1..65535).
REQ-003 clk  input  1  single clock; every flop SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  upstream offers an operand set.
REQ-006 in_ready  output  1  block accepts the operand set this cycle.
REQ-007 in_a, in_b  input  WIDTH each  binary operands.
REQ-008 in_op  input  2  binary ALU opcode.
REQ-009 a_t, a_f, b_t, b_f  output  WIDTH each  dual-rail operand rails to the downstream ALU stage.
REQ-010 op_t, op_f  output  2 each  dual-rail opcode rails.
REQ-011 ack_in  input  1  asynchronous NCL completion from downstream; 1 = request-for-data, 0 = request-for-null.
REQ-012 tok_cnt  output  16  count of completed DATA/NULL cycles.
REQ-013 erro  output  1  sticky timeout flag.

Function
REQ-014 ack_in SHALL pass through a 2-flop synchronizer; ack_s is the second flop, and all control uses ack_s only.
REQ-015 FSM states: NULO (rails NULL) and DADO (rails DATA).
REQ-016 In NULO, in_ready SHALL equal ack_s, combinationally.
REQ-017 In NULO, when in_valid and in_ready are both 1 at an edge: latch the operands, enter DADO, and drive the encoded rails from the next cycle (latency 1).
REQ-018 Encoding per bit: value 1 -> t=1, f=0; value 0 -> t=0, f=1.
REQ-019 In NULO, all rails SHALL be 0; in_valid with ack_s=0 SHALL be ignored and no operand is latched.
REQ-020 In DADO, in_ready SHALL be 0, and rails SHALL hold the latched value unchanged regardless of in_* inputs.
REQ-021 In DADO, when ack_s=0 at an edge: return to NULO, drive all rails to 0 from the next cycle, and increment tok_cnt.
REQ-022 tok_cnt SHALL wrap from 0xFFFF to 0x0000.
REQ-023 No rail pair SHALL ever read t=1 and f=1 together.
REQ-024 Rails SHALL never change directly from one DATA value to another; a NULL wavefront of at least 1 cycle always intervenes.
REQ-025 All rails, tok_cnt and erro SHALL be registered outputs; in_ready is the only combinational output.

Reset
REQ-026 On rst=1 at an edge, regardless of state, the block SHALL load: state NULO, all rails 0, both synchronizer flops 0, tok_cnt 0, erro 0, timeout counter 0.
REQ-027 A reset while in DADO SHALL drop the rails to NULL on the next cycle and SHALL NOT increment tok_cnt.
REQ-028 After reset, in_ready stays 0 for at least 2 cycles, until ack_in=1 has propagated through the synchronizer.

Configuration
REQ-029 With macro INJETOR_NCL_TIMEOUT_EN defined: a 16-bit counter clears on entering DADO and increments each cycle in DADO. When it reaches TIMEOUT, erro SHALL set to 1 and stay 1 until rst. The FSM is unaffected and keeps waiting.
REQ-030 Without INJETOR_NCL_TIMEOUT_EN: the counter is absent, erro is tied to 0, and the TIMEOUT parameter is unused.

Verification
REQ-031 Reset, then hold ack_in=1 -> in_ready=0 for 2 cycles, then 1; all rails 0; tok_cnt=0.
REQ-032 WIDTH=4, in_a=4'b1010, in_b=4'b0011, in_op=2'b01, accepted -> next cycle a_t=1010, a_f=0101, b_t=0011, b_f=1100, op_t=01, op_f=10.
REQ-033 Drop ack_in while in DADO -> rails all 0 exactly 3 cycles after the ack_in edge (2 synchronizer cycles + 1 register cycle); tok_cnt increments by 1.
REQ-034 Hold in_valid=1 with ack_in=0 -> no acceptance and rails stay NULL; change in_a while in DADO -> rails unchanged.
REQ-035 Preload tok_cnt=0xFFFF by running 65535 tokens, then complete 1 more token -> tok_cnt=0x0000.
REQ-036 With INJETOR_NCL_TIMEOUT_EN, TIMEOUT=8, ack_in held 1 in DADO -> erro=1 after 8 cycles in DADO, stays 1 after ack_in falls, and clears only on rst.
